// File: rtl/sram_pixel_reader.sv
// sram_pixel_reader: streams 8-bit pixels from the SRAM bus slave into a FWFT FIFO.
// Ports: clk/bReset, start/base_addr/pix_count, AddressBus/DataBus/ControlBus, pix_*, busy/done/err.
module sram_pixel_reader #(
   parameter int READ_LAT      = 2,
   parameter int FIFO_DEPTH    = 8,
   parameter int GRANT_TIMEOUT = 64
) (
   input  logic        clk,
   input  logic        bReset,
   input  logic        start,
   input  logic [17:0] base_addr,
   input  logic [17:0] pix_count,
   output logic [31:0] AddressBus,
   input  logic [7:0]  DataBus,
   input  logic        ControlBus,
   output logic [7:0]  pix_data,
   output logic        pix_valid,
   input  logic        pix_ready,
   output logic        busy,
   output logic        done,
   output logic        err
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
   localparam int TW = $clog2(GRANT_TIMEOUT + 1);

   localparam logic [LW-1:0] LAT_LAST = LW'(READ_LAT - 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(GRANT_TIMEOUT - 1);
   localparam logic [AW:0]   DEPTH_C  = (AW + 1)'(FIFO_DEPTH);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_ATTACH  = 3'd1;
   localparam logic [2:0] S_WAIT    = 3'd2;
   localparam logic [2:0] S_CAPTURE = 3'd3;
   localparam logic [2:0] S_STALL   = 3'd4;
   localparam logic [2:0] S_DONE    = 3'd5;

   logic [2:0]    state;
   logic [17:0]   cur_addr;
   logic [17:0]   remaining;
   logic [LW-1:0] lat_cnt;
   logic [TW-1:0] to_cnt;
   logic          err_q;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;
   logic [AW:0]   count_next;
   logic          push;
   logic          pop;
   logic          full;
   logic          bus_active;

   // A capture only lands while the slave still owns the bus.
   assign push = (state == S_CAPTURE) && !ControlBus;
   assign pop  = (count != '0) && pix_ready;
   assign full = (count == DEPTH_C);
   assign count_next = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};

   assign bus_active = (state == S_ATTACH) || (state == S_WAIT) ||
                       (state == S_CAPTURE) || (state == S_STALL);

   // Device 1, bCE low, bWE high (read); device 0 releases the slave.
   assign AddressBus = bus_active ? {4'b0001, 8'h00, 1'b0, 1'b1, cur_addr}
                                  : 32'h0;

   assign pix_data  = mem[rd_ptr];
   assign pix_valid = (count != '0);
   assign busy      = (state != S_IDLE);
   assign done      = (state == S_DONE);
   assign err       = err_q;

   always_ff @(posedge clk) begin
      if (bReset && push) begin
         mem[wr_ptr] <= DataBus;
      end
   end

   always_ff @(posedge clk) begin
      if (!bReset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         count <= count_next;
      end
   end

   always_ff @(posedge clk) begin
      if (!bReset) begin
         state     <= S_IDLE;
         cur_addr  <= '0;
         remaining <= '0;
         lat_cnt   <= '0;
         to_cnt    <= '0;
         err_q     <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (start) begin
                  cur_addr  <= base_addr;
                  remaining <= pix_count;
                  err_q     <= 1'b0;
                  to_cnt    <= '0;
                  state     <= (pix_count == 18'd0) ? S_DONE : S_ATTACH;
               end
            end
            S_ATTACH: begin
               if (!ControlBus) begin
                  lat_cnt <= '0;
                  state   <= S_WAIT;
               end else if (to_cnt == TO_LAST) begin
                  err_q <= 1'b1;
                  state <= S_DONE;
               end else begin
                  to_cnt <= to_cnt + TW'(1);
               end
            end
            S_WAIT: begin
               if (ControlBus) begin
                  to_cnt <= '0;
                  state  <= S_ATTACH;
               end else if (lat_cnt == LAT_LAST) begin
                  state <= S_CAPTURE;
               end else begin
                  lat_cnt <= lat_cnt + LW'(1);
               end
            end
            S_CAPTURE: begin
               if (ControlBus) begin
                  // Grant lost: re-read the same address.
                  to_cnt <= '0;
                  state  <= S_ATTACH;
               end else begin
                  cur_addr  <= cur_addr + 18'd1;
                  remaining <= remaining - 18'd1;
                  if (remaining == 18'd1) begin
                     state <= S_DONE;
                  end else if (count_next != DEPTH_C) begin
                     lat_cnt <= '0;
                     state   <= S_WAIT;
                  end else begin
                     state <= S_STALL;
                  end
               end
            end
            S_STALL: begin
               if (!full) begin
                  lat_cnt <= '0;
                  state   <= S_WAIT;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule
